// File: rtl/pe_vc_src.sv
`default_nettype none
// ============================================================================
// Module   : pe_vc_src
// Purpose  : Memory-image flit injector for a PE's local router port.
//            Streams preloaded flits on NVC virtual channels with per-VC
//            credit flow control, packet-atomic VC locking, wrap/one-shot
//            addressing and injection counters.
// Options  : define PE_INJ_GAP_EN to insert GAP idle cycles after each
//            packet (adds parameter GAP and state S_GAP).
// Revision : 1.0 - initial release
// ============================================================================
module pe_vc_src #(
    parameter int DATAW     = 34,
    parameter int DEPTH     = 256,
    parameter int FLITS     = 256,
    parameter int NVC       = 2,
    parameter int VCW       = 1,
    parameter int BUF_DEPTH = 4,
    parameter int TYPE_LSB  = 32,
    parameter int VCH_LSB   = 30,
    parameter int WRAP      = 1
`ifdef PE_INJ_GAP_EN
    ,
    parameter int GAP       = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             rd_en,
    input  logic             grt,
    input  logic [NVC-1:0]   credit_in,
    output logic             req,
    output logic             ovalid,
    output logic [DATAW-1:0] odata,
    output logic [VCW-1:0]   ovch,
    output logic             empty,
    output logic [15:0]      sent_cnt,
    output logic [15:0]      pkt_cnt,
    output logic             err
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(BUF_DEPTH + 1);
    localparam int NSLOT = 1 << VCW;

    localparam logic [AW-1:0] LAST_ADDR = AW'(FLITS - 1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(BUF_DEPTH);

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

`ifdef PE_INJ_GAP_EN
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    typedef enum logic [1:0] {
        S_HEAD = 2'd0,
        S_BODY = 2'd1,
        S_DONE = 2'd2,
        S_GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_HEAD = 2'd0,
        S_BODY = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    // Flit image, preloaded externally (e.g. by the testbench)
    logic [DATAW-1:0] memory [DEPTH];

    state_t          state;
    logic [AW-1:0]   rd_addr;
    logic [VCW-1:0]  lock_vc;
    logic [CW-1:0]   credit [NVC];
`ifdef PE_INJ_GAP_EN
    logic [GW-1:0]   gap_cnt;
`endif

    logic [DATAW-1:0] cur;
    logic [1:0]       ftype;
    logic [VCW-1:0]   head_vc;
    logic [VCW-1:0]   vc_sel;
    logic [NSLOT-1:0] cred_nz;
    logic [NVC-1:0]   dec;
    logic [NVC-1:0]   ovf;
    logic             active;
    logic             seq_err;
    logic             pkt_end;
    logic             pkt_close;

    // Current flit decode, VC selection, request and output muxing
    always_comb begin
        cur     = memory[rd_addr];
        ftype   = cur[TYPE_LSB +: 2];
        head_vc = cur[VCH_LSB +: VCW];
        // Body flits stay on the VC locked by their head
        vc_sel  = (state == S_BODY) ? lock_vc : head_vc;

        // Unpopulated VC slots (NVC not a power of two) never have credit
        cred_nz = '0;
        for (int v = 0; v < NVC; v++) begin
            cred_nz[v] = (credit[v] != '0);
        end

        active = (state == S_HEAD) || (state == S_BODY);
        req    = rd_en && !empty && cred_nz[vc_sel] && active;
        ovalid = req && grt;
        odata  = ovalid ? cur : '0;
        ovch   = ovalid ? vc_sel : '0;
    end

    // Per-VC credit consumption and overflow detection
    always_comb begin
        dec = '0;
        ovf = '0;
        for (int v = 0; v < NVC; v++) begin
            dec[v] = ovalid && (vc_sel == VCW'(v));
            ovf[v] = credit_in[v] && !dec[v] && (credit[v] == CRED_MAX);
        end
    end

    // Flit-type sequence checking and packet-boundary classification
    always_comb begin
        seq_err   = ovalid &&
                    (((state == S_HEAD) && ((ftype == T_BODY) || (ftype == T_TAIL))) ||
                     ((state == S_BODY) && ((ftype == T_HEAD) || (ftype == T_HT))));
        pkt_end   = ovalid && ((ftype == T_TAIL) || (ftype == T_HT));
        // A packet legitimately closes on a head+tail, or on a tail inside a packet
        pkt_close = (ftype == T_HT) || ((ftype == T_TAIL) && (state == S_BODY));
        empty     = (state == S_DONE);
    end

    // Credit counters: return and send in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int v = 0; v < NVC; v++) begin
                credit[v] <= CRED_MAX;
            end
        end else begin
            for (int v = 0; v < NVC; v++) begin
                if (credit_in[v] && !dec[v]) begin
                    if (credit[v] != CRED_MAX) begin
                        credit[v] <= credit[v] + CW'(1);
                    end
                end else if (dec[v] && !credit_in[v]) begin
                    credit[v] <= credit[v] - CW'(1);
                end
            end
        end
    end

    // Packet FSM, address sequencing, VC lock, counters and sticky error
    always_ff @(posedge clk) begin
        if (rst_) begin
            state    <= S_HEAD;
            rd_addr  <= '0;
            lock_vc  <= '0;
            sent_cnt <= '0;
            pkt_cnt  <= '0;
            err      <= 1'b0;
`ifdef PE_INJ_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            if (seq_err || (|ovf)) begin
                err <= 1'b1;
            end

            if (ovalid && (sent_cnt != 16'hFFFF)) begin
                sent_cnt <= sent_cnt + 16'd1;
            end
            if (pkt_end && (pkt_cnt != 16'hFFFF)) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end

            case (state)
                S_HEAD, S_BODY: begin
                    if (ovalid) begin
                        // Any head (even an out-of-sequence one) re-locks the VC
                        if ((ftype == T_HEAD) || (ftype == T_HT)) begin
                            lock_vc <= head_vc;
                        end
                        if ((WRAP == 0) && (rd_addr == LAST_ADDR)) begin
                            state <= S_DONE;
                        end else begin
                            rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);
                            if (ftype == T_HEAD) begin
                                state <= S_BODY;
                            end else if (pkt_close) begin
`ifdef PE_INJ_GAP_EN
                                state   <= S_GAP;
                                gap_cnt <= GW'(GAP - 1);
`else
                                state   <= S_HEAD;
`endif
                            end
                            // Body stays put; a stray tail in S_HEAD stays in S_HEAD
                        end
                    end
                end
`ifdef PE_INJ_GAP_EN
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_HEAD;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
`endif
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_HEAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_vc_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_vc_src
// Purpose  : Self-checking bench for pe_vc_src. Two instances: dut_a wraps,
//            dut_b is one-shot; both 8-entry images on 2 VCs, 4 credits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_vc_src;

    localparam int DATAW = 34;
    localparam int NF    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             a_rst, a_rd_en, a_grt;
    logic [1:0]       a_cin;
    logic             a_req, a_ovalid, a_empty, a_err;
    logic [DATAW-1:0] a_odata;
    logic [0:0]       a_ovch;
    logic [15:0]      a_sent, a_pkt;

    logic             b_rst, b_rd_en, b_grt;
    logic [1:0]       b_cin;
    logic             b_req, b_ovalid, b_empty, b_err;
    logic [DATAW-1:0] b_odata;
    logic [0:0]       b_ovch;
    logic [15:0]      b_sent, b_pkt;

    pe_vc_src #(.DATAW(DATAW), .DEPTH(NF), .FLITS(NF), .NVC(2), .VCW(1), .BUF_DEPTH(4),
                .TYPE_LSB(32), .VCH_LSB(30), .WRAP(1)) dut_a (
        .clk(clk), .rst_(a_rst), .rd_en(a_rd_en), .grt(a_grt), .credit_in(a_cin),
        .req(a_req), .ovalid(a_ovalid), .odata(a_odata), .ovch(a_ovch), .empty(a_empty),
        .sent_cnt(a_sent), .pkt_cnt(a_pkt), .err(a_err));

    pe_vc_src #(.DATAW(DATAW), .DEPTH(NF), .FLITS(NF), .NVC(2), .VCW(1), .BUF_DEPTH(4),
                .TYPE_LSB(32), .VCH_LSB(30), .WRAP(0)) dut_b (
        .clk(clk), .rst_(b_rst), .rd_en(b_rd_en), .grt(b_grt), .credit_in(b_cin),
        .req(b_req), .ovalid(b_ovalid), .odata(b_odata), .ovch(b_ovch), .empty(b_empty),
        .sent_cnt(b_sent), .pkt_cnt(b_pkt), .err(b_err));

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATAW-1:0] img [NF];

    localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, HT = 2'b11;

    function automatic logic [DATAW-1:0] mk(input logic [1:0] t, input logic vc);
        logic [29:0] pay;
        pay = 30'($urandom);
        return {t, 1'b0, vc, pay};
    endfunction

    task automatic load_a();
        for (int i = 0; i < NF; i++) dut_a.memory[i] = img[i];
    endtask

    task automatic load_b();
        for (int i = 0; i < NF; i++) dut_b.memory[i] = img[i];
    endtask

    task automatic reset_a();
        @(negedge clk);
        a_rst = 1'b1; a_rd_en = 1'b0; a_grt = 1'b0; a_cin = 2'b00;
        @(negedge clk);
        a_rst = 1'b0;
    endtask

    task automatic reset_b();
        @(negedge clk);
        b_rst = 1'b1; b_rd_en = 1'b0; b_grt = 1'b0; b_cin = 2'b00;
        @(negedge clk);
        b_rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NF; i++) img[i] = mk(HT, 1'b0);
        load_a(); load_b();
        reset_a(); reset_b();
        #1;
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", a_req); end
        n_checks++; if (a_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid got %b exp 0", a_ovalid); end
        n_checks++; if (a_odata !== '0) begin n_fail++; $display("FAIL reset_odata got %h exp 0", a_odata); end
        n_checks++; if (a_ovch !== 1'b0) begin n_fail++; $display("FAIL reset_ovch got %b exp 0", a_ovch); end
        n_checks++; if (a_empty !== 1'b0 || b_empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty got %b/%b exp 0/0", a_empty, b_empty); end
        n_checks++; if (a_sent !== 16'd0 || a_pkt !== 16'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d exp 0/0", a_sent, a_pkt); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", a_err); end
        n_checks++; if (dut_a.credit[0] !== 3'd4 || dut_a.credit[1] !== 3'd4) begin n_fail++; $display("FAIL reset_credit got %0d/%0d exp 4/4", dut_a.credit[0], dut_a.credit[1]); end
        n_checks++; if (dut_a.rd_addr !== 3'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", dut_a.rd_addr); end
        // Grant without request is ignored
        a_grt = 1'b1;
        #1;
        n_checks++; if (a_ovalid !== 1'b0) begin n_fail++; $display("FAIL grt_no_req got %b exp 0", a_ovalid); end
        a_rd_en = 1'b1;
        #1;
        n_checks++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL req_after_rd_en got %b exp 1", a_req); end
    endtask

    task automatic test_vc_packet();
        img[0] = mk(H, 1'b1); img[1] = mk(B, 1'b1); img[2] = mk(B, 1'b1); img[3] = mk(T, 1'b1);
        img[4] = mk(H, 1'b1); img[5] = mk(T, 1'b1); img[6] = mk(HT, 1'b0); img[7] = mk(HT, 1'b0);
        load_a(); reset_a();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); a_rd_en = 1'b1; a_grt = 1'b1; a_cin = 2'b00; #1;
            n_checks++; if (a_ovalid !== 1'b1 || a_ovch !== 1'b1) begin n_fail++; $display("FAIL vcpkt_send%0d got v=%b ch=%b exp 1/1", i, a_ovalid, a_ovch); end
            n_checks++; if (a_odata !== img[i]) begin n_fail++; $display("FAIL vcpkt_data%0d got %h exp %h", i, a_odata, img[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++; if (a_req !== 1'b0 || a_ovalid !== 1'b0) begin n_fail++; $display("FAIL vcpkt_nocredit got req=%b v=%b exp 0/0", a_req, a_ovalid); end
        end
        n_checks++; if (dut_a.credit[1] !== 3'd0) begin n_fail++; $display("FAIL vcpkt_credit1 got %0d exp 0", dut_a.credit[1]); end
        n_checks++; if (a_pkt !== 16'd1 || a_sent !== 16'd4) begin n_fail++; $display("FAIL vcpkt_counts got %0d/%0d exp 1/4", a_pkt, a_sent); end
        @(negedge clk); a_cin = 2'b10; #1;
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL vcpkt_pulse_cycle got %b exp 0", a_req); end
        @(negedge clk); a_cin = 2'b00; #1;
        n_checks++; if (a_ovalid !== 1'b1 || a_ovch !== 1'b1 || a_odata !== img[4]) begin n_fail++; $display("FAIL vcpkt_resume got v=%b ch=%b d=%h exp 1/1/%h", a_ovalid, a_ovch, a_odata, img[4]); end
    endtask

    task automatic test_credit_stall();
        img[0] = mk(HT, 1'b0); img[1] = mk(HT, 1'b0); img[2] = mk(HT, 1'b0); img[3] = mk(H, 1'b0);
        img[4] = mk(B, 1'b0);  img[5] = mk(T, 1'b0);  img[6] = mk(HT, 1'b1); img[7] = mk(HT, 1'b1);
        load_a(); reset_a();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); a_rd_en = 1'b1; a_grt = 1'b1; a_cin = 2'b00; #1;
            n_checks++; if (a_ovalid !== 1'b1 || a_odata !== img[i]) begin n_fail++; $display("FAIL stall_pre%0d got v=%b d=%h exp 1/%h", i, a_ovalid, a_odata, img[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); a_cin = (i == 2) ? 2'b01 : 2'b00; #1;
            n_checks++; if (a_req !== 1'b0 || dut_a.rd_addr !== 3'd4) begin n_fail++; $display("FAIL stall_hold%0d got req=%b addr=%0d exp 0/4", i, a_req, dut_a.rd_addr); end
        end
        @(negedge clk); a_cin = 2'b00; #1;
        n_checks++; if (a_ovalid !== 1'b1 || a_ovch !== 1'b0 || a_odata !== img[4]) begin n_fail++; $display("FAIL stall_resume got v=%b ch=%b d=%h exp 1/0/%h", a_ovalid, a_ovch, a_odata, img[4]); end
    endtask

    task automatic test_credit_corner();
        for (int i = 0; i < NF; i++) img[i] = mk(HT, 1'b0);
        load_a(); reset_a();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); a_rd_en = 1'b1; a_grt = 1'b1; a_cin = (i == 2) ? 2'b01 : 2'b00; #1;
            n_checks++; if (a_ovalid !== 1'b1) begin n_fail++; $display("FAIL corner_send%0d got %b exp 1", i, a_ovalid); end
        end
        @(negedge clk); a_rd_en = 1'b0; a_cin = 2'b00; #1;
        n_checks++; if (dut_a.credit[0] !== 3'd2 || a_err !== 1'b0) begin n_fail++; $display("FAIL corner_cancel got cr=%0d err=%b exp 2/0", dut_a.credit[0], a_err); end
        @(negedge clk); a_cin = 2'b10;
        @(negedge clk); a_cin = 2'b00; #1;
        n_checks++; if (a_err !== 1'b1 || dut_a.credit[1] !== 3'd4) begin n_fail++; $display("FAIL corner_overflow got err=%b cr=%0d exp 1/4", a_err, dut_a.credit[1]); end
    endtask

    task automatic test_body_first_and_reset();
        img[0] = mk(B, 1'b0); img[1] = mk(T, 1'b0); img[2] = mk(H, 1'b1); img[3] = mk(B, 1'b0);
        for (int i = 4; i < NF; i++) img[i] = mk(HT, 1'b0);
        load_a(); reset_a();
        @(negedge clk); a_rd_en = 1'b1; a_grt = 1'b1; a_cin = 2'b00; #1;
        n_checks++; if (a_ovalid !== 1'b1 || a_odata !== img[0]) begin n_fail++; $display("FAIL body0_sent got v=%b d=%h exp 1/%h", a_ovalid, a_odata, img[0]); end
        @(negedge clk); #1;
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL body0_err got %b exp 1", a_err); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        // Body flit's own VC field is 0; it must go out on the locked VC 1
        n_checks++; if (a_ovalid !== 1'b1 || a_ovch !== 1'b1) begin n_fail++; $display("FAIL midpkt_body got v=%b ch=%b exp 1/1", a_ovalid, a_ovch); end
        @(negedge clk); a_rd_en = 1'b0; a_rst = 1'b1;
        @(negedge clk); a_rst = 1'b0; #1;
        n_checks++; if (dut_a.rd_addr !== 3'd0 || a_err !== 1'b0 || a_sent !== 16'd0) begin n_fail++; $display("FAIL midrst_state got addr=%0d err=%b sent=%0d exp 0/0/0", dut_a.rd_addr, a_err, a_sent); end
        n_checks++; if (dut_a.credit[0] !== 3'd4 || dut_a.credit[1] !== 3'd4) begin n_fail++; $display("FAIL midrst_credit got %0d/%0d exp 4/4", dut_a.credit[0], dut_a.credit[1]); end
        // A body flit after reset must be flagged, showing the FSM is back awaiting a head
        @(negedge clk); a_rd_en = 1'b1; #1;
        n_checks++; if (a_ovalid !== 1'b1) begin n_fail++; $display("FAIL midrst_send got %b exp 1", a_ovalid); end
        @(negedge clk); a_rd_en = 1'b0; #1;
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL midrst_head_state got err=%b exp 1", a_err); end
    endtask

    task automatic test_wrap_count();
        for (int i = 0; i < NF; i++) img[i] = mk(HT, 1'(i % 2));
        load_a(); reset_a();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); a_rd_en = 1'b1; a_grt = 1'b1; a_cin = 2'(1 << (i % 2)); #1;
            n_checks++; if (a_ovalid !== 1'b1 || a_ovch !== 1'(i % 2) || a_empty !== 1'b0) begin n_fail++; $display("FAIL wrap_send%0d got v=%b ch=%b e=%b exp 1/%0d/0", i, a_ovalid, a_ovch, a_empty, i % 2); end
        end
        @(negedge clk); a_rd_en = 1'b0; a_grt = 1'b0; a_cin = 2'b00; #1;
        n_checks++; if (a_sent !== 16'd20 || a_pkt !== 16'd20) begin n_fail++; $display("FAIL wrap_counts got %0d/%0d exp 20/20", a_sent, a_pkt); end
        n_checks++; if (dut_a.rd_addr !== 3'd4 || a_empty !== 1'b0 || a_err !== 1'b0) begin n_fail++; $display("FAIL wrap_addr got addr=%0d e=%b err=%b exp 4/0/0", dut_a.rd_addr, a_empty, a_err); end
    endtask

    task automatic test_one_shot();
        img[0] = mk(H, 1'b0); img[1] = mk(B, 1'b0); img[2] = mk(T, 1'b0); img[3] = mk(HT, 1'b0);
        img[4] = mk(H, 1'b0); img[5] = mk(B, 1'b0); img[6] = mk(B, 1'b0); img[7] = mk(T, 1'b0);
        load_b(); reset_b();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); b_rd_en = 1'b1; b_grt = 1'b1; b_cin = (i < 8) ? 2'b01 : 2'b00; #1;
            n_checks++; if (b_ovalid !== (i < 8) || b_empty !== (i >= 8)) begin n_fail++; $display("FAIL oneshot_c%0d got v=%b e=%b exp %0d/%0d", i, b_ovalid, b_empty, i < 8, i >= 8); end
            if (i < 8) begin
                n_checks++; if (b_odata !== img[i]) begin n_fail++; $display("FAIL oneshot_data%0d got %h exp %h", i, b_odata, img[i]); end
            end
        end
        n_checks++; if (b_sent !== 16'd8 || b_pkt !== 16'd3 || b_err !== 1'b0) begin n_fail++; $display("FAIL oneshot_final got s=%0d p=%0d err=%b exp 8/3/0", b_sent, b_pkt, b_err); end
        b_rd_en = 1'b0; b_grt = 1'b0;
    endtask

    // Random traffic against a packet-level model of the injector
    task automatic test_random();
        int pos, len, vc;
        int mcred [2];
        int maddr, msent, mpkts;
        bit inpkt;
        int mlock, cvc;
        logic [1:0] ft;
        bit ereq, esend;
        pos = 0;
        while (pos < NF) begin
            vc  = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 4));
            if (pos + len > NF) len = NF - pos;
            for (int k = 0; k < len; k++) begin
                if (len == 1)            img[pos + k] = mk(HT, 1'(vc));
                else if (k == 0)         img[pos + k] = mk(H, 1'(vc));
                else if (k == len - 1)   img[pos + k] = mk(T, 1'(1 - vc));
                else                     img[pos + k] = mk(B, 1'(1 - vc));
            end
            pos += len;
        end
        load_a(); reset_a();
        mcred[0] = 4; mcred[1] = 4; maddr = 0; msent = 0; mpkts = 0; inpkt = 0; mlock = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            a_rd_en = ($urandom_range(0, 3) != 0);
            a_grt   = ($urandom_range(0, 9) < 7);
            for (int v = 0; v < 2; v++) a_cin[v] = (mcred[v] < 4) && ($urandom_range(0, 2) == 0);
            #1;
            ft    = img[maddr][33:32];
            cvc   = inpkt ? mlock : int'(img[maddr][30]);
            ereq  = a_rd_en && (mcred[cvc] > 0);
            esend = ereq && a_grt;
            n_checks++; if (a_req !== ereq || a_ovalid !== esend) begin n_fail++; $display("FAIL rand_hs c%0d got req=%b v=%b exp %b/%b", c, a_req, a_ovalid, ereq, esend); end
            if (esend) begin
                n_checks++; if (a_odata !== img[maddr] || a_ovch !== 1'(cvc)) begin n_fail++; $display("FAIL rand_flit c%0d got %h/%b exp %h/%0d", c, a_odata, a_ovch, img[maddr], cvc); end
            end
            for (int v = 0; v < 2; v++) mcred[v] += int'(a_cin[v]) - ((esend && cvc == v) ? 1 : 0);
            if (esend) begin
                msent++;
                if (ft == H) begin inpkt = 1; mlock = int'(img[maddr][30]); end
                else if (ft == T || ft == HT) begin inpkt = 0; mpkts++; end
                maddr = (maddr + 1) % NF;
            end
        end
        @(negedge clk); a_rd_en = 1'b0; a_grt = 1'b0; a_cin = 2'b00; #1;
        n_checks++; if (a_sent !== 16'(msent) || a_pkt !== 16'(mpkts)) begin n_fail++; $display("FAIL rand_counts got %0d/%0d exp %0d/%0d", a_sent, a_pkt, msent, mpkts); end
        n_checks++; if (a_err !== 1'b0 || dut_a.credit[0] !== 3'(mcred[0]) || dut_a.credit[1] !== 3'(mcred[1])) begin n_fail++; $display("FAIL rand_final got err=%b cr=%0d/%0d exp 0/%0d/%0d", a_err, dut_a.credit[0], dut_a.credit[1], mcred[0], mcred[1]); end
    endtask

    initial begin
        a_rst = 1'b1; a_rd_en = 1'b0; a_grt = 1'b0; a_cin = 2'b00;
        b_rst = 1'b1; b_rd_en = 1'b0; b_grt = 1'b0; b_cin = 2'b00;
        test_reset();
        test_vc_packet();
        test_credit_stall();
        test_credit_corner();
        test_body_first_and_reset();
        test_wrap_count();
        test_one_shot();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
